// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types and constants for the multiply/divide unit
package md_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - unsigned shift-add multiply / restoring divide datapath
module md_iter_core #(
    parameter int WIDTH = md_pkg::MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_mult,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] q,
    output logic             last
);

    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;

    // Multiply: {acc,q} shifts right with the partial sum entering at the top.
    // Divide: {acc,q} shifts left, acc holds the running remainder.
    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        div_shift = {acc, q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_reg};
        div_ok    = ~div_trial[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            q     <= '0;
            b_reg <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= '0;
            q     <= a_mag;
            b_reg <= b_mag;
            cnt   <= CNT_W'(WIDTH);
        end else if (step) begin
            cnt <= cnt - 1'b1;
            if (is_mult) begin
                acc <= mul_sum[WIDTH:1];
                q   <= {mul_sum[0], q[WIDTH-1:1]};
            end else begin
                acc <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], div_ok};
            end
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MIPS multiply/divide unit with HI/LO; MD_DIV0_FLAG_EN adds div_zero
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mult,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mt_wen,
    input  logic             mt_is_hi,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             rd_req,
    input  logic             rd_is_hi,
    input  logic             kill,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
`ifdef MD_DIV0_FLAG_EN
    output logic             div_zero,
`endif
    output logic             stall
);

    md_state_e state, state_nxt;

    logic [WIDTH-1:0]   hi, lo;
    logic               mult_r, res_neg, a_neg, div0_r;
    logic               accept, a_neg_in, b_neg_in, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               core_load, core_step, core_last;
    logic [WIDTH-1:0]   core_acc, core_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               fix_commit, write_en, mt_write;

    assign accept   = (state == ST_IDLE) & start & ~kill;
    assign a_neg_in = ~is_unsigned & op_a[WIDTH-1];
    assign b_neg_in = ~is_unsigned & op_b[WIDTH-1];
    assign a_mag    = a_neg_in ? -op_a : op_a;
    assign b_mag    = b_neg_in ? -op_b : op_b;
    assign b_zero   = (op_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mult ? ST_MUL : (b_zero ? ST_FIX : ST_DIV);
            ST_MUL,
            ST_DIV:  if (kill) state_nxt = ST_IDLE;
                     else if (core_last) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        core_load  = accept;
        core_step  = ((state == ST_MUL) | (state == ST_DIV)) & ~kill;
        fix_commit = (state == ST_FIX) & ~kill;
        stall      = busy & (start | mt_wen | rd_req);
    end

    md_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (core_load),
        .step    (core_step),
        .is_mult (mult_r),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .acc     (core_acc),
        .q       (core_q),
        .last    (core_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_r  <= 1'b0;
            res_neg <= 1'b0;
            a_neg   <= 1'b0;
            div0_r  <= 1'b0;
        end else if (accept) begin
            mult_r  <= is_mult;
            res_neg <= a_neg_in ^ b_neg_in;
            a_neg   <= a_neg_in;
            div0_r  <= ~is_mult & b_zero;
        end
    end

    // Remainder takes the dividend's sign; quotient/product take the XOR of signs.
    always_comb begin
        prod_fix = res_neg ? -{core_acc, core_q} : {core_acc, core_q};
        quo_fix  = res_neg ? -core_q : core_q;
        rem_fix  = a_neg ? -core_acc : core_acc;
    end

    assign write_en = fix_commit & ~div0_r;
    assign mt_write = mt_wen & ~busy & ~kill & ~start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (write_en) begin
            if (mult_r) begin
                {hi, lo} <= prod_fix;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end else if (mt_write) begin
            if (mt_is_hi == SEL_HI) hi <= mt_data;
            else                    lo <= mt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= fix_commit;
    end

`ifdef MD_DIV0_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_zero <= 1'b0;
        else        div_zero <= fix_commit & div0_r;
    end
`endif

    assign rd_data = (rd_is_hi == SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against an arithmetic model
module tb_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         start = 1'b0, is_mult = 1'b0, is_unsigned = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0, mt_data = '0;
    logic         mt_wen = 1'b0, mt_is_hi = 1'b0, rd_req = 1'b0, rd_is_hi = 1'b0, kill = 1'b0;
    logic [W-1:0] rd_data;
    logic         busy, done, stall;
`ifdef MD_DIV0_FLAG_EN
    logic         div_zero;
`endif

    md_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_mult     (is_mult),
        .is_unsigned (is_unsigned),
        .op_a        (op_a),
        .op_b        (op_b),
        .mt_wen      (mt_wen),
        .mt_is_hi    (mt_is_hi),
        .mt_data     (mt_data),
        .rd_req      (rd_req),
        .rd_is_hi    (rd_is_hi),
        .kill        (kill),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
`ifdef MD_DIV0_FLAG_EN
        .div_zero    (div_zero),
`endif
        .stall       (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {write, hi, lo} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [2*W:0] md_result(input logic mult, input logic uns,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r, qq, rr;
        sa = uns ? longint'(a) : longint'(signed'(a));
        sb = uns ? longint'(b) : longint'(signed'(b));
        if (mult) begin
            r = sa * sb;
            return {1'b1, r[63:0]};
        end
        if (b == '0) return {1'b0, 64'd0};
        qq = sa / sb;
        rr = sa % sb;
        return {1'b1, rr[W-1:0], qq[W-1:0]};
    endfunction

    logic [W-1:0]   m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic           p_write = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    int             m_cnt = 0;
    logic [2*W:0]   res_now;

    assign res_now = md_result(is_mult, is_unsigned, op_a, op_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_cnt <= 0; m_done <= 1'b0; m_dz <= 1'b0; p_write <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_cnt > 0) begin
                if (kill) begin
                    m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        if (p_write) begin
                            m_hi <= p_hi;
                            m_lo <= p_lo;
                        end
                        m_done <= 1'b1;
                        m_dz   <= ~p_write;
                    end
                end
            end else if (start && !kill) begin
                p_write <= res_now[2*W];
                p_hi    <= res_now[2*W-1:W];
                p_lo    <= res_now[W-1:0];
                m_cnt   <= res_now[2*W] ? W + 1 : 1;
            end else if (mt_wen && !kill) begin
                if (mt_is_hi) m_hi <= mt_data;
                else          m_lo <= mt_data;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_cnt > 0);
        check("done", done, m_done);
        check("stall", stall, (m_cnt > 0) && (start || mt_wen || rd_req));
        check("rd_data", rd_data, rd_is_hi ? m_hi : m_lo);
`ifdef MD_DIV0_FLAG_EN
        check("div_zero", div_zero, m_dz);
`endif
    end

    logic dz_at_done = 1'b0;

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
`ifdef MD_DIV0_FLAG_EN
                dz_at_done = div_zero;
`endif
                break;
            end
        end
        if (lat == 0) check("done_timeout", 0, 1);
    endtask

    task automatic op(input logic mult, input logic uns, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int lat);
        start = 1'b1; is_mult = mult; is_unsigned = uns; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic h, input logic [W-1:0] exp, input string name);
        rd_is_hi = h;
        @(negedge clk);
        check(name, rd_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic mt(input logic h, input logic [W-1:0] d);
        mt_wen = 1'b1; mt_is_hi = h; mt_data = d;
        @(posedge clk); #1;
        mt_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'h5, lat);
        check("mult_lat", lat, 34);
        rd(1'b1, 32'hFFFF_FFFF, "mult_hi");
        rd(1'b0, 32'hFFFF_FFF1, "mult_lo");

        op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'h5, lat);
        rd(1'b1, 32'h4, "multu_hi");
        rd(1'b0, 32'hFFFF_FFF1, "multu_lo");

        op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'h2, lat);
        check("div_lat", lat, 34);
        rd(1'b0, 32'hFFFF_FFFD, "div_lo");
        rd(1'b1, 32'hFFFF_FFFF, "div_hi");

        op(1'b0, 1'b1, 32'h7, 32'h2, lat);
        rd(1'b0, 32'h3, "divu_lo");
        rd(1'b1, 32'h1, "divu_hi");

        op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        rd(1'b0, 32'h8000_0000, "ovf_lo");
        rd(1'b1, 32'h0, "ovf_hi");

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        rd(1'b1, 32'h11, "mthi");
        rd(1'b0, 32'h22, "mtlo");
        op(1'b0, 1'b0, 32'h9, 32'h0, lat);
        check("div0_lat", lat, 2);
`ifdef MD_DIV0_FLAG_EN
        check("div0_flag", dz_at_done, 1);
`endif
        rd(1'b1, 32'h11, "div0_hi");
        rd(1'b0, 32'h22, "div0_lo");

        // MFHI five cycles into a multiply must stall until the done cycle
        start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b1; op_a = 32'h1234_5678; op_b = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rd_req = 1'b1; rd_is_hi = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("mfhi_nostall", stall, 0);
                check("mfhi_data", rd_data, 32'h1);
                break;
            end
            check("mfhi_stall", stall, 1);
        end
        if (seen == 0) check("mfhi_timeout", 0, 1);
        @(posedge clk); #1;
        rd_req = 1'b0;
        rd(1'b0, 32'h2345_6780, "mfhi_lo");

        // kill in cycle 10 of a divide, then restart immediately
        start = 1'b1; is_mult = 1'b0; is_unsigned = 1'b0; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        start = 1'b1; is_unsigned = 1'b1; rd_is_hi = 1'b1;
        @(negedge clk);
        check("kill_busy", busy, 0);
        check("kill_done", done, 0);
        check("kill_hi_kept", rd_data, 32'h1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("after_kill_lat", lat, 34);
        @(posedge clk); #1;
        rd(1'b0, 32'd14, "after_kill_lo");
        rd(1'b1, 32'd2, "after_kill_hi");

        // asynchronous reset in the middle of a multiply
        start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b0; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_stall", stall, 0);
        check("arst_rd", rd_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(1'b1, 32'h0, "post_rst_hi");
        rd(1'b0, 32'h0, "post_rst_lo");
        op(1'b1, 1'b0, 32'd6, 32'd7, lat);
        check("post_rst_lat", lat, 34);
        rd(1'b0, 32'd42, "post_rst_lo2");
        rd(1'b1, 32'd0, "post_rst_hi2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
